mac_buf_ctrl: RTL and testbench

MAC_BUF_CTRL -- requirements
Module: mac_buf_ctrl

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_buf_ctrl_if.sv | 31 +++
 rtl/mac_buf_ctrl.sv | 102 ++++++++++
 tb/tb_mac_buf_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC operand-buffer controller.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int PassCntWidth   = 8;
  localparam int DefDataWidth   = 8;
  localparam int DefBufferSize  = 4;
  localparam int DefBufferWidth = 2;

endpackage

// File: rtl/mac_buf_ctrl_if.sv
// Operand-side and MAC-side handshake plus Buffer address/enable bus.
interface mac_buf_ctrl_if #(
  parameter int BufferWidth = mac_pkg::DefBufferWidth
);

  // Both channels use strict valid/ready: a transfer occurs on a rising clk
  // edge where valid and ready are both high; valid never waits on ready and,
  // once raised, the payload stays stable until the transfer completes.
  logic                   in_valid;
  logic                   in_ready;
  logic                   buf_en;
  logic [BufferWidth-1:0] buf_waddr;
  logic [BufferWidth-1:0] buf_raddr1;
  logic [BufferWidth-1:0] buf_raddr2;
  logic                   mac_valid;
  logic                   mac_ready;
  logic                   mac_last;

  modport master (
    input  in_valid, mac_ready,
    output in_ready, buf_en, buf_waddr, buf_raddr1, buf_raddr2,
           mac_valid, mac_last
  );

  modport slave (
    output in_valid, mac_ready,
    input  in_ready, buf_en, buf_waddr, buf_raddr1, buf_raddr2,
           mac_valid, mac_last
  );

endinterface

// File: rtl/mac_buf_ctrl.sv
// Fill/issue controller: fills the operand Buffer, then issues slot pairs to the MAC.
// Optional MAC_BUF_ACC_CLR_EN adds acc_clr, a one-cycle pulse at each pass start.
module mac_buf_ctrl
  import mac_pkg::*;
#(
  parameter int DataWidth   = DefDataWidth,
  parameter int BufferSize  = DefBufferSize,
  parameter int BufferWidth = DefBufferWidth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef MAC_BUF_ACC_CLR_EN
  output logic                    acc_clr,
`endif
  output logic                    done,
  output logic                    busy,
  output logic [PassCntWidth-1:0] pass_cnt,
  output logic [1:0]              state_dbg,
  mac_buf_ctrl_if.master          bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FILL  = FILL;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [BufferWidth-1:0] WrLast = BufferWidth'(BufferSize - 1);
  localparam logic [BufferWidth-1:0] KLast  = BufferWidth'(BufferSize / 2 - 1);
  localparam logic [BufferWidth-1:0] One    = BufferWidth'(1);

  // DataWidth only sizes the companion Buffer; it is checked here for sanity.
  if (BufferSize < 2 || (BufferSize % 2) != 0 ||
      (1 << BufferWidth) != BufferSize || DataWidth < 1) begin : g_bad_params
    $error("mac_buf_ctrl: inconsistent DataWidth/BufferSize/BufferWidth");
  end

  logic [1:0]             state;
  logic [BufferWidth-1:0] wr_ptr;
  logic [BufferWidth-1:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      k        <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FILL;
        end
        S_FILL: begin
          if (bus.buf_en) begin
            if (wr_ptr == WrLast) begin
              wr_ptr <= '0;
              state  <= S_ISSUE;
            end else begin
              wr_ptr <= wr_ptr + One;
            end
          end
        end
        S_ISSUE: begin
          if (bus.mac_ready) begin
            if (k == KLast) begin
              k     <= '0;
              state <= S_DONE;
            end else begin
              k <= k + One;
            end
          end
        end
        S_DONE: begin
          pass_cnt <= pass_cnt + PassCntWidth'(1);
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MAC_BUF_ACC_CLR_EN
  // Registered so the pulse lines up with the first FILL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_clr <= 1'b0;
    else        acc_clr <= (state == S_IDLE) && start;
  end
`endif

  assign bus.in_ready   = (state == S_FILL);
  assign bus.buf_en     = bus.in_valid & bus.in_ready;
  assign bus.buf_waddr  = wr_ptr;
  assign bus.mac_valid  = (state == S_ISSUE);
  assign bus.mac_last   = (state == S_ISSUE) && (k == KLast);
  // Pair k lives in slots 2k and 2k+1; idle addresses park on slots 0 and 1.
  assign bus.buf_raddr1 = (state == S_ISSUE) ? BufferWidth'({k, 1'b0}) : '0;
  assign bus.buf_raddr2 = (state == S_ISSUE) ? BufferWidth'({k, 1'b1}) : One;
  assign done           = (state == S_DONE);
  assign busy           = (state != S_IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_mac_buf_ctrl.sv
// Directed bench for mac_buf_ctrl with a behavioural Buffer model alongside it.
module tb_mac_buf_ctrl;
  import mac_pkg::*;

  localparam int DW = 8;
  localparam int BS = 4;
  localparam int BW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic          busy;
  logic [7:0]    pass_cnt;
  logic [1:0]    state_dbg;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] mem [BS];
  logic [DW-1:0] words [4];
  logic          pat [6];
  int            checks   = 0;
  int            failures = 0;
  int            wr_seen  = 0;
  int            nwr;
`ifdef MAC_BUF_ACC_CLR_EN
  logic          acc_clr;
  int            acc_cnt  = 0;
`endif

  mac_buf_ctrl_if #(.BufferWidth(BW)) bus ();

  mac_buf_ctrl #(
    .DataWidth  (DW),
    .BufferSize (BS),
    .BufferWidth(BW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef MAC_BUF_ACC_CLR_EN
    .acc_clr  (acc_clr),
`endif
    .done     (done),
    .busy     (busy),
    .pass_cnt (pass_cnt),
    .state_dbg(state_dbg),
    .bus      (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Buffer model: one write port, two combinational read ports
  always @(posedge clk) begin
    if (bus.buf_en) begin
      mem[bus.buf_waddr] <= din;
      wr_seen++;
    end
  end

`ifdef MAC_BUF_ACC_CLR_EN
  always @(negedge clk) if (acc_clr === 1'b1) acc_cnt++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks are entered just after a falling edge.
  task automatic begin_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef MAC_BUF_ACC_CLR_EN
    check("acc_clr_pulse", acc_clr, 1'b1);
`endif
  endtask

  task automatic fill_words(input logic [DW-1:0] base);
    for (int i = 0; i < BS; i++) begin
      bus.in_valid = 1'b1;
      din          = base + DW'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
  endtask

`ifdef MAC_BUF_ACC_CLR_EN
  task automatic run_pass(input logic [DW-1:0] base);
    begin_pass();
    fill_words(base);
    bus.mac_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mac_ready = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mac_ready = 1'b0;

    // reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",      busy,           1'b0);
    check("rst_in_ready",  bus.in_ready,   1'b0);
    check("rst_mac_valid", bus.mac_valid,  1'b0);
    check("rst_pass_cnt",  pass_cnt,       8'd0);
    check("rst_raddr1",    bus.buf_raddr1, 2'd0);
    check("rst_raddr2",    bus.buf_raddr2, 2'd1);
    check("rst_done",      done,           1'b0);
    check("rst_state",     state_dbg,      IDLE);

    // full pass, no stalls
    begin_pass();
    check("fp_state_fill", state_dbg,    FILL);
    check("fp_in_ready",   bus.in_ready, 1'b1);
    check("fp_busy",       busy,         1'b1);
    for (int i = 0; i < BS; i++) begin
      bus.in_valid = 1'b1;
      din          = words[i];
      #1;
      check("fp_buf_en", bus.buf_en,    1'b1);
      check("fp_waddr",  bus.buf_waddr, i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    check("fp_p0_valid",  bus.mac_valid,       1'b1);
    check("fp_p0_raddr1", bus.buf_raddr1,      2'd0);
    check("fp_p0_raddr2", bus.buf_raddr2,      2'd1);
    check("fp_p0_data1",  mem[bus.buf_raddr1], 8'h11);
    check("fp_p0_data2",  mem[bus.buf_raddr2], 8'h22);
    check("fp_p0_last",   bus.mac_last,        1'b0);
    check("fp_p0_inrdy",  bus.in_ready,        1'b0);
    bus.mac_ready = 1'b1;
    @(negedge clk);
    check("fp_p1_raddr1", bus.buf_raddr1,      2'd2);
    check("fp_p1_raddr2", bus.buf_raddr2,      2'd3);
    check("fp_p1_data1",  mem[bus.buf_raddr1], 8'h33);
    check("fp_p1_data2",  mem[bus.buf_raddr2], 8'h44);
    check("fp_p1_last",   bus.mac_last,        1'b1);
    @(negedge clk);
    bus.mac_ready = 1'b0;
    check("fp_done",      done,           1'b1);
    check("fp_dn_valid",  bus.mac_valid,  1'b0);
    check("fp_dn_last",   bus.mac_last,   1'b0);
    check("fp_dn_raddr1", bus.buf_raddr1, 2'd0);
    check("fp_dn_raddr2", bus.buf_raddr2, 2'd1);
    @(negedge clk);
    check("fp_done_off",  done,     1'b0);
    check("fp_idle_busy", busy,     1'b0);
    check("fp_pass_cnt",  pass_cnt, 8'd1);

    // backpressure on pair 0
    begin_pass();
    fill_words(8'hA0);
    for (int j = 0; j < 3; j++) begin
      check("bp_valid",  bus.mac_valid,  1'b1);
      check("bp_raddr1", bus.buf_raddr1, 2'd0);
      check("bp_raddr2", bus.buf_raddr2, 2'd1);
      check("bp_data1",  mem[bus.buf_raddr1], 8'hA0);
      if (j == 2) bus.mac_ready = 1'b1;
      @(negedge clk);
    end
    check("bp_p1_raddr1", bus.buf_raddr1, 2'd2);
    check("bp_p1_raddr2", bus.buf_raddr2, 2'd3);
    check("bp_p1_last",   bus.mac_last,   1'b1);
    @(negedge clk);
    bus.mac_ready = 1'b0;
    check("bp_done", done, 1'b1);
    @(negedge clk);
    check("bp_pass_cnt", pass_cnt, 8'd2);

    // input stall: in_valid 1,0,0,1,1,1
    wr_seen = 0;
    nwr     = 0;
    begin_pass();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = pat[i];
      din          = 8'hC0 + DW'(nwr);
      #1;
      check("st_state",  state_dbg,     FILL);
      check("st_buf_en", bus.buf_en,    pat[i]);
      check("st_waddr",  bus.buf_waddr, nwr);
      if (pat[i]) nwr++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    check("st_writes",   wr_seen,             4);
    check("st_issue",    state_dbg,           ISSUE);
    check("st_wr_wrap",  bus.buf_waddr,       2'd0);
    check("st_p0_data1", mem[bus.buf_raddr1], 8'hC0);
    check("st_p0_data2", mem[bus.buf_raddr2], 8'hC1);
    bus.mac_ready = 1'b1;
    @(negedge clk);
    check("st_p1_data1", mem[bus.buf_raddr1], 8'hC2);
    check("st_p1_data2", mem[bus.buf_raddr2], 8'hC3);
    @(negedge clk);
    bus.mac_ready = 1'b0;
    check("st_done", done, 1'b1);
    @(negedge clk);
    check("st_pass_cnt", pass_cnt, 8'd3);

    // reset mid-ISSUE, start ignored while issuing
    begin_pass();
    fill_words(8'hD0);
    start         = 1'b1;
    bus.mac_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ri_state", state_dbg,    ISSUE);
    check("ri_last",  bus.mac_last, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ri_state_idle", state_dbg,      IDLE);
    check("ri_busy",       busy,           1'b0);
    check("ri_valid",      bus.mac_valid,  1'b0);
    check("ri_done",       done,           1'b0);
    check("ri_pass_cnt",   pass_cnt,       8'd0);
    check("ri_raddr2",     bus.buf_raddr2, 2'd1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mac_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("ri_post_done", done,     1'b0);
      check("ri_post_busy", busy,     1'b0);
      check("ri_post_cnt",  pass_cnt, 8'd0);
    end

`ifdef MAC_BUF_ACC_CLR_EN
    // 256 passes: one acc_clr per pass, pass_cnt wraps back to 0
    acc_cnt = 0;
    for (int p = 0; p < 256; p++) begin
      run_pass(DW'(p));
      if (p == 254) check("acc_cnt_255", pass_cnt, 8'd255);
    end
    check("acc_pulses",   acc_cnt,  256);
    check("acc_cnt_wrap", pass_cnt, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
